// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
// Port indices name the requesters; the helper advances the round-robin pointer.
package sdram_arb_pkg;

    localparam int NPORTS = 3;

    localparam logic [1:0] P_68K = 2'd0;
    localparam logic [1:0] P_Z80 = 2'd1;
    localparam logic [1:0] P_GFX = 2'd2;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        GUARD,
        WAIT
    } state_t;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            P_68K:   return P_Z80;
            P_Z80:   return P_GFX;
            default: return P_68K;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 3.
module rr_pick3
    import sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [1:0]        ptr,
    output logic              valid,
    output logic [1:0]        idx
);

    always_comb begin
        logic [2:0] cand;
        // NOTE: every output gets a default before the scan so no path leaves a latch.
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 3'd0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NPORTS)) begin
                cand = cand - 3'(NPORTS);
            end
            if (!valid && req[cand[1:0]]) begin
                valid = 1'b1;
                idx   = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter serialising three requesters onto the edge-triggered SDRAM
// controller rd/we interface, with a post-issue guard window and a WAIT watchdog.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int AW        = 25,
    parameter int GUARD_CYC = 2,
    parameter int TMO_CYC   = 255
) (
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    req_we,
    input  logic [NPORTS*AW-1:0] req_addr,
    input  logic [NPORTS*16-1:0] req_din,
    input  logic [NPORTS*2-1:0]  req_wtbt,
    output logic [15:0]          rsp_dout,
    output logic [NPORTS-1:0]    ack,
    output logic                 err,
    output logic [AW-1:0]        sd_addr,
    output logic [15:0]          sd_din,
    output logic [1:0]           sd_wtbt,
    output logic                 sd_rd,
    output logic                 sd_we,
    input  logic [15:0]          sd_dout,
    input  logic                 sd_ready
);

    localparam int TW = $clog2(TMO_CYC + 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        g;
    logic [1:0]        rr_ptr;
    logic              we_g;
    logic [2:0]        guard;
    logic [TW-1:0]     tmo;
    logic              tmo_hit;
    logic [NPORTS-1:0] req_live;
    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic [NPORTS-1:0] ack_g;

    // A port whose ack is high this cycle may still hold req; it is not a new request yet.
    assign req_live = req & ~ack;
    assign tmo_hit  = (tmo == TW'(TMO_CYC - 1));

    always_comb begin
        ack_g    = '0;
        ack_g[g] = 1'b1;
    end

    rr_pick3 u_pick (
        .req   (req_live),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sd_ready) state_nxt = IDLE;
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = GUARD;
            GUARD:   if (guard == 3'd0) state_nxt = WAIT;
            WAIT:    if (sd_ready || tmo_hit) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // NOTE: all state below uses <= so every branch sees pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            sd_rd    <= 1'b0;
            sd_we    <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            rsp_dout <= 16'h0000;
            sd_addr  <= '0;
            sd_din   <= 16'h0000;
            sd_wtbt  <= 2'b00;
            rr_ptr   <= P_68K;
            g        <= P_68K;
            we_g     <= 1'b0;
            guard    <= 3'd0;
            tmo      <= '0;
        end else begin
            sd_rd <= 1'b0;
            sd_we <= 1'b0;
            ack   <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        g       <= pick_idx;
                        we_g    <= req_we[pick_idx];
                        sd_addr <= req_addr[int'(pick_idx)*AW +: AW];
                        sd_din  <= req_din[int'(pick_idx)*16 +: 16];
                        sd_wtbt <= req_wtbt[int'(pick_idx)*2 +: 2];
                        // Strobe is registered here so it is high for exactly the ISSUE cycle.
                        sd_rd   <= ~req_we[pick_idx];
                        sd_we   <= req_we[pick_idx];
                    end
                end
                ISSUE: begin
                    guard <= 3'(GUARD_CYC - 1);
                    tmo   <= '0;
                end
                GUARD: begin
                    if (guard != 3'd0) begin
                        guard <= guard - 3'd1;
                    end
                end
                WAIT: begin
                    if (sd_ready) begin
                        if (!we_g) begin
                            rsp_dout <= sd_dout;
                        end
                        ack    <= ack_g;
                        rr_ptr <= next_port(g);
                    end else if (tmo_hit) begin
                        err      <= 1'b1;
                        rsp_dout <= 16'hFFFF;
                        ack      <= ack_g;
                        rr_ptr   <= next_port(g);
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
